// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - default register-address width and multicycle timeout
//   - FSM state encoding
//   - packed bundle of the pipeline control outputs
//   - helper for the timeout counter width
package hazard_pkg;

  localparam int REG_W_DEF      = 5;
  localparam int MC_TIMEOUT_DEF = 64;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hc_state_e;

  // Bit order is the order the testbench and top pack the outputs in.
  typedef struct packed {
    logic mc_start;
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_bubble;
  } hc_ctrl_t;

  // clog2 of the timeout, floored at one bit so tiny timeouts still build.
  function automatic int tmo_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard statistics.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset, clears the count
//   inc_i  - count this cycle
//   cnt_o  - current count, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use interlock, branch flush and
// multicycle (mul/div) handshake with timeout abort.
// Ports:
//   clk, rst_n                    - clock and synchronous active-low reset
//   id_rs1/id_rs2, id_uses_rs*    - ID-stage source registers and use flags
//   ex_mem_read, ex_rd            - EX instruction is a load, its destination
//   ex_is_mc                      - EX instruction is multicycle
//   ex_branch_taken               - redirect resolved in EX
//   mc_done                       - multicycle result valid pulse
//   mc_start                      - start pulse to the multicycle unit
//   pc_stall/if_id_stall/id_ex_stall       - hold registers
//   if_id_flush/id_ex_bubble/ex_mem_bubble - squash into NOP
//   mc_error                      - sticky multicycle timeout flag
//   stall_cnt, flush_cnt          - saturating statistics
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_W      = REG_W_DEF,
  parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_mc,
  input  logic             ex_branch_taken,
  input  logic             mc_done,
  output logic             mc_start,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mc_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              TMO_W    = tmo_width(MC_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MC_TIMEOUT - 1);

  hc_state_e        state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             rst_dly_q;   // high for the one cycle following reset
  logic             blank;
  logic             load_use;
  hc_ctrl_t         ctrl;
  logic [CNT_W-1:0] stall_cnt_raw, flush_cnt_raw;

  // Outputs are forced quiet while reset is applied and for one cycle after,
  // so the pipeline around us has time to settle before we act on inputs.
  assign blank = !rst_n || rst_dly_q;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                     (id_uses_rs2 && (ex_rd == id_rs2)));

  // Priority: multicycle > branch flush > load-use. In MC_BUSY the ID/EX
  // register is held (or released by mc_done/timeout), so neither a branch
  // nor a load-use can be acted on there.
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    if (!blank) begin
      unique case (state_q)
        RUN: begin
          if (ex_is_mc) begin
            ctrl.mc_start      = 1'b1;
            ctrl.pc_stall      = 1'b1;
            ctrl.if_id_stall   = 1'b1;
            ctrl.id_ex_stall   = 1'b1;
            ctrl.ex_mem_bubble = 1'b1;
            state_d            = MC_BUSY;
            tmo_d              = '0;
          end else if (ex_branch_taken) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
          end else if (load_use) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
          end
        end
        MC_BUSY: begin
          if (mc_done) begin
            // Result is ready: everything advances on this edge.
            state_d = RUN;
          end else if (tmo_q == TMO_LAST) begin
            // Abort: let the pipeline move, drop the stuck op as a bubble.
            ctrl.ex_mem_bubble = 1'b1;
            err_d              = 1'b1;
            state_d            = RUN;
          end else begin
            ctrl.pc_stall      = 1'b1;
            ctrl.if_id_stall   = 1'b1;
            ctrl.id_ex_stall   = 1'b1;
            ctrl.ex_mem_bubble = 1'b1;
            tmo_d              = tmo_q + TMO_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      rst_dly_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      rst_dly_q <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (ctrl.pc_stall),
    .cnt_o (stall_cnt_raw)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (ctrl.if_id_flush),
    .cnt_o (flush_cnt_raw)
  );

  assign mc_start      = ctrl.mc_start;
  assign pc_stall      = ctrl.pc_stall;
  assign if_id_stall   = ctrl.if_id_stall;
  assign id_ex_stall   = ctrl.id_ex_stall;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign mc_error      = blank ? 1'b0 : err_q;
  assign stall_cnt     = blank ? '0 : stall_cnt_raw;
  assign flush_cnt     = blank ? '0 : flush_cnt_raw;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: each step drives inputs, queues the
// expected outputs, then pops and compares them at the falling edge.
module tb_hazard_controller;

  localparam int REG_W      = 5;
  localparam int MC_TIMEOUT = 8;
  localparam int CNT_W      = 4;

  // {mc_start, pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_bubble, ex_mem_bubble}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b0110010;
  localparam logic [6:0] MCS  = 7'b1111001;
  localparam logic [6:0] MCB  = 7'b0111001;
  localparam logic [6:0] BR   = 7'b0000110;
  localparam logic [6:0] TMO  = 7'b0000001;

  typedef struct {
    string            tag;
    logic [6:0]       ctrl;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_mc;
  logic             ex_branch_taken, mc_done;
  logic             mc_start, pc_stall, if_id_stall, id_ex_stall;
  logic             if_id_flush, id_ex_bubble, ex_mem_bubble, mc_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Reference model state: counts and error flag as they stand now.
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;
  logic             m_err   = 1'b0;
  logic             m_blank = 1'b0;

  always #5 clk = ~clk;

  hazard_controller #(.REG_W(REG_W), .MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_is_mc(ex_is_mc), .ex_branch_taken(ex_branch_taken), .mc_done(mc_done),
    .mc_start(mc_start), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .mc_error(mc_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic drv(input logic u1, input logic [REG_W-1:0] rs1,
                     input logic u2, input logic [REG_W-1:0] rs2,
                     input logic mr, input logic [REG_W-1:0] rd,
                     input logic mc, input logic br, input logic done);
    id_uses_rs1 = u1; id_rs1 = rs1;
    id_uses_rs2 = u2; id_rs2 = rs2;
    ex_mem_read = mr; ex_rd  = rd;
    ex_is_mc = mc; ex_branch_taken = br; mc_done = done;
  endtask

  task automatic step(input string tag, input logic [6:0] ec, input bit set_err);
    exp_t e, x;
    logic [6:0] obs;
    bit g;
    g      = !rst_n || m_blank;
    e.tag  = tag;
    e.ctrl = ec;
    e.scnt = g ? '0 : m_stall;
    e.fcnt = g ? '0 : m_flush;
    e.err  = g ? 1'b0 : m_err;
    exp_q.push_back(e);
    @(negedge clk);
    x   = exp_q.pop_front();
    obs = {mc_start, pc_stall, if_id_stall, id_ex_stall,
           if_id_flush, id_ex_bubble, ex_mem_bubble};
    checks++;
    assert (obs === x.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl got %b want %b", x.tag, obs, x.ctrl);
    end
    checks++;
    assert (stall_cnt === x.scnt) else begin
      errors++;
      $error("FAIL %s stall_cnt got %0d want %0d", x.tag, stall_cnt, x.scnt);
    end
    checks++;
    assert (flush_cnt === x.fcnt) else begin
      errors++;
      $error("FAIL %s flush_cnt got %0d want %0d", x.tag, flush_cnt, x.fcnt);
    end
    checks++;
    assert (mc_error === x.err) else begin
      errors++;
      $error("FAIL %s mc_error got %b want %b", x.tag, mc_error, x.err);
    end
    // Advance the model to what the next rising edge commits.
    if (!rst_n) begin
      m_stall = '0; m_flush = '0; m_err = 1'b0; m_blank = 1'b1;
    end else begin
      m_blank = 1'b0;
      if (ec[5] && m_stall != '1) m_stall = m_stall + CNT_W'(1);
      if (ec[2] && m_flush != '1) m_flush = m_flush + CNT_W'(1);
      if (set_err) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with hazards present on the inputs: outputs must stay quiet.
    rst_n = 1'b0;
    drv(1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 1, 1);
    step("rst0", NONE, 0);
    step("rst1", NONE, 0);
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("post_rst_mc", NONE, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle", NONE, 0);

    // Load-use interlock.
    drv(0, 0, 1, 5'd5, 1, 5'd5, 0, 0, 0);
    step("lu_rs2", LU, 0);
    drv(0, 0, 1, 5'd5, 0, 5'd5, 0, 0, 0);
    step("lu_release", NONE, 0);
    drv(1, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0);
    step("lu_x0", NONE, 0);
    drv(0, 5'd7, 0, 5'd7, 1, 5'd7, 0, 0, 0);
    step("lu_unused", NONE, 0);
    drv(1, 5'd3, 1, 5'd4, 1, 5'd9, 0, 0, 0);
    step("lu_nomatch", NONE, 0);
    drv(1, 5'd31, 0, 0, 1, 5'd31, 0, 0, 0);
    step("lu_rs1", LU, 0);

    // Branch flush beats load-use.
    drv(1, 5'd31, 0, 0, 1, 5'd31, 0, 1, 0);
    step("br_lu", BR, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("br", BR, 0);

    // Multicycle op, done after four busy cycles; branch/load-use ignored.
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("mc_start", MCS, 0);
    drv(1, 5'd2, 0, 0, 1, 5'd2, 1, 1, 0);
    step("mc_busy0", MCB, 0);
    step("mc_busy1", MCB, 0);
    step("mc_busy2", MCB, 0);
    step("mc_busy3", MCB, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("mc_done", NONE, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("done_in_run", NONE, 0);

    // Back-to-back short op: start, then done immediately.
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("mc2_start", MCS, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("mc2_done", NONE, 0);

    // Timeout: mc_done never arrives. Stall counter saturates on the way.
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("tmo_start", MCS, 0);
    for (int i = 0; i < MC_TIMEOUT - 1; i++) step($sformatf("tmo_busy%0d", i), MCB, 0);
    step("tmo_abort", TMO, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("tmo_after", NONE, 0);
    drv(0, 0, 1, 5'd8, 1, 5'd8, 0, 0, 0);
    step("lu_sat0", LU, 0);
    step("lu_sat1", LU, 0);

    // Flush counter to saturation.
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 14; i++) step($sformatf("br_sat%0d", i), BR, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("flush_sat", NONE, 0);

    // Reset in the middle of a multicycle op.
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("rm_start", MCS, 0);
    step("rm_busy", MCB, 0);
    rst_n = 1'b0;
    step("rm_rst", NONE, 0);
    rst_n = 1'b1;
    step("rm_post", NONE, 0);
    step("rm_restart", MCS, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("rm_done", NONE, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rm_idle", NONE, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-address width.
REQ-002 SHALL have parameter MC_TIMEOUT, default 64, meaning max MC_BUSY cycles before abort.
REQ-003 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports id_rs1, id_rs2  input  REG_W  ID-stage source registers.
REQ-007 SHALL have ports id_uses_rs1, id_uses_rs2  input  1  ID instruction reads that source.
REQ-008 SHALL have ports ex_mem_read  input  1 and ex_rd  input  REG_W  EX instruction is a load, and its destination.
REQ-009 SHALL have port ex_is_mc  input  1  EX instruction is multicycle (mul/div).
REQ-010 SHALL have port ex_branch_taken  input  1  redirect resolved in EX.
REQ-011 SHALL have port mc_done  input  1  multicycle unit result valid (one-cycle pulse).
REQ-012 SHALL have port mc_start  output  1  one-cycle start pulse to multicycle unit.
REQ-013 SHALL have ports pc_stall, if_id_stall, id_ex_stall  output  1  hold the respective register.
REQ-014 SHALL have ports if_id_flush, id_ex_bubble, ex_mem_bubble  output  1  squash into NOP.
REQ-015 SHALL have port mc_error  output  1  sticky timeout flag.
REQ-016 SHALL have ports stall_cnt, flush_cnt  output  CNT_W  saturating statistics.

Function
REQ-017 SHALL implement FSM states RUN, MC_BUSY; control outputs combinational from state and inputs.
REQ-018 load_use SHALL be ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
REQ-019 In RUN with load_use and no higher-priority event: pc_stall=1, if_id_stall=1, id_ex_bubble=1, for exactly that cycle.
REQ-020 In RUN with ex_is_mc=1: mc_start=1, pc/if_id/id_ex stalls=1, ex_mem_bubble=1; next state MC_BUSY.
REQ-021 In MC_BUSY with mc_done=0: all three stalls=1, ex_mem_bubble=1, mc_start=0, timeout counter increments.
REQ-022 In MC_BUSY with mc_done=1: all stalls and bubbles 0 (instruction advances this edge); next state RUN.
REQ-023 mc_done SHALL be ignored in RUN; mc_start SHALL never assert in two consecutive cycles.
REQ-024 If the timeout counter reaches MC_TIMEOUT-1 without mc_done: set mc_error, release stalls that cycle with ex_mem_bubble=1, return to RUN.
REQ-025 ex_branch_taken in RUN: if_id_flush=1, id_ex_bubble=1, pc_stall=0, if_id_stall=0; overrides load_use in the same cycle.
REQ-026 Priority: MC (RUN with ex_is_mc, or MC_BUSY) > branch flush > load_use; load_use bubble suppressed while ID/EX is held.
REQ-027 ex_branch_taken in MC_BUSY SHALL be ignored (cannot legally occur).
REQ-028 stall_cnt SHALL increment on each cycle with pc_stall=1; flush_cnt on each cycle with if_id_flush=1; both saturate at all-ones.
REQ-029 Timeout counter SHALL clear on entry to MC_BUSY; width is clog2(MC_TIMEOUT).

Reset
REQ-030 While rst_n=0 at a rising edge: state=RUN, counters=0, mc_error=0.
REQ-031 During and one cycle after reset all outputs SHALL be 0 regardless of inputs, and reset mid-MC_BUSY SHALL abandon the operation without a mc_start.
REQ-032 mc_error SHALL clear only by reset.

Structure
REQ-033 The state enum, REG_W default and MC_TIMEOUT default SHALL live in shared package hazard_pkg.
REQ-034 The saturating counter SHALL be sub-module sat_counter, instantiated twice (stall_cnt, flush_cnt).

Verification
REQ-035 Load x5 in EX (ex_rd=5), ID reads id_rs2=5 -> one cycle pc_stall=if_id_stall=id_ex_bubble=1; stall_cnt 0->1.
REQ-036 ex_rd=0 load, id_rs1=0 -> no stall.
REQ-037 ex_is_mc=1, mc_done 4 cycles later -> mc_start one pulse, stalls for 5 cycles, released in the mc_done cycle, stall_cnt=5.
REQ-038 ex_branch_taken with concurrent load_use -> if_id_flush=id_ex_bubble=1, pc_stall=0, flush_cnt=1.
REQ-039 MC_TIMEOUT=8, mc_done never asserted -> mc_error=1 after 8 MC_BUSY-related cycles, state RUN, stays set until rst_n=0.
REQ-040 rst_n=0 asserted mid-MC_BUSY -> next cycle state RUN, all outputs 0, counters 0.
